// File: rtl/wb_regs_pkg.sv
// Shared constants for the writeback stage and integer register file.
package wb_regs_pkg;

    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned XLEN_DEF = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One register-file read port: x0 -> ex bypass -> wb bypass -> array, in priority order.
module regfile_bypass_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic [AW-1:0]   raddr_i,
    input  logic [XLEN-1:0] arr_word_i,
    input  logic            wb_wen_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_wen_i,
    input  logic [AW-1:0]   ex_addr_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            enable_ex_i,
    output logic [XLEN-1:0] rdata_o
);

    always_comb begin
        rdata_o = arr_word_i;
        if (raddr_i == '0) begin
            rdata_o = '0;
        end else if (enable_ex_i && ex_wen_i && (ex_addr_i == raddr_i)) begin
            rdata_o = ex_data_i;
        end else if (wb_wen_i && (wb_addr_i == raddr_i)) begin
            rdata_o = wb_data_i;
        end
    end

endmodule

// File: rtl/wb_regs.sv
// Writeback register plus flop-based integer register file with bypassed read ports.
module wb_regs
    import wb_regs_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = REG_NUM,
    parameter int unsigned AW     = REG_AW,
    parameter bit          FWD_EX = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rd_wen_i,
    input  logic [AW-1:0]   rs1_raddr_i,
    input  logic [AW-1:0]   rs2_raddr_i,
    output logic [XLEN-1:0] rs1_rdata_o,
    output logic [XLEN-1:0] rs2_rdata_o,
    input  logic [AW-1:0]   dbg_raddr_i,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            wb_busy_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wb_wen_q;
    logic            wb_wen_d;
    logic [AW-1:0]   wb_addr_q;
    logic [XLEN-1:0] wb_data_q;
    logic [XLEN-1:0] dbg_rdata_d;
    logic [XLEN-1:0] dbg_rdata_q;

    // Writes to x0 die here so they never occupy the wb entry.
    assign wb_wen_d = rd_wen_i && (rd_addr_i != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            wb_wen_q    <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (wb_wen_q) begin
                regs_q[wb_addr_q] <= wb_data_q;
            end
            wb_wen_q    <= wb_wen_d;
            wb_addr_q   <= rd_addr_i;
            wb_data_q   <= rd_data_i;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    regfile_bypass_mux #(
        .XLEN(XLEN),
        .AW  (AW)
    ) u_rs1_mux (
        .raddr_i    (rs1_raddr_i),
        .arr_word_i (regs_q[rs1_raddr_i]),
        .wb_wen_i   (wb_wen_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .ex_wen_i   (rd_wen_i),
        .ex_addr_i  (rd_addr_i),
        .ex_data_i  (rd_data_i),
        .enable_ex_i(FWD_EX),
        .rdata_o    (rs1_rdata_o)
    );

    regfile_bypass_mux #(
        .XLEN(XLEN),
        .AW  (AW)
    ) u_rs2_mux (
        .raddr_i    (rs2_raddr_i),
        .arr_word_i (regs_q[rs2_raddr_i]),
        .wb_wen_i   (wb_wen_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .ex_wen_i   (rd_wen_i),
        .ex_addr_i  (rd_addr_i),
        .ex_data_i  (rd_data_i),
        .enable_ex_i(FWD_EX),
        .rdata_o    (rs2_rdata_o)
    );

    // Debug port never sees ex's in-flight result.
    regfile_bypass_mux #(
        .XLEN(XLEN),
        .AW  (AW)
    ) u_dbg_mux (
        .raddr_i    (dbg_raddr_i),
        .arr_word_i (regs_q[dbg_raddr_i]),
        .wb_wen_i   (wb_wen_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .ex_wen_i   (rd_wen_i),
        .ex_addr_i  (rd_addr_i),
        .ex_data_i  (rd_data_i),
        .enable_ex_i(1'b0),
        .rdata_o    (dbg_rdata_d)
    );

    assign dbg_rdata_o = dbg_rdata_q;
    assign wb_busy_o   = wb_wen_q;

endmodule

// File: tb/tb_wb_regs.sv
// Bench for wb_regs: vector table for the fwd DUT, reference model and dbg scoreboard for both.
module tb_wb_regs;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [4:0]  rs1_raddr;
    logic [4:0]  rs2_raddr;
    logic [4:0]  dbg_raddr;
    logic [31:0] rs1_rdata, rs2_rdata, dbg_rdata;
    logic        wb_busy;
    logic [31:0] rs1_rdata0, rs2_rdata0, dbg_rdata0;
    logic        wb_busy0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] dbg_q [$];

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  da;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [$];

    wb_regs #(
        .XLEN(32), .NREG(32), .AW(5), .FWD_EX(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_i  (rd_data),
        .rd_wen_i   (rd_wen),
        .rs1_raddr_i(rs1_raddr),
        .rs2_raddr_i(rs2_raddr),
        .rs1_rdata_o(rs1_rdata),
        .rs2_rdata_o(rs2_rdata),
        .dbg_raddr_i(dbg_raddr),
        .dbg_rdata_o(dbg_rdata),
        .wb_busy_o  (wb_busy)
    );

    wb_regs #(
        .XLEN(32), .NREG(32), .AW(5), .FWD_EX(1'b0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_i  (rd_data),
        .rd_wen_i   (rd_wen),
        .rs1_raddr_i(rs1_raddr),
        .rs2_raddr_i(rs2_raddr),
        .rs1_rdata_o(rs1_rdata0),
        .rs2_rdata_o(rs2_rdata0),
        .dbg_raddr_i(dbg_raddr),
        .dbg_rdata_o(dbg_rdata0),
        .wb_busy_o  (wb_busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input bit use_ex);
        if (a == 5'd0) return 32'd0;
        if (use_ex && rd_wen && rd_addr == a) return rd_data;
        if (m_wen && m_addr == a) return m_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_wen  = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        dbg_q.delete();
    endtask

    // Drive one cycle at negedge; compare comb reads, then registered outputs after the edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        rd_wen    = v.wen;
        rd_addr   = v.addr;
        rd_data   = v.data;
        rs1_raddr = v.ra1;
        rs2_raddr = v.ra2;
        dbg_raddr = v.da;
        #1;
        chk("rs1_fwd", rs1_rdata, v.e1);
        chk("rs2_fwd", rs2_rdata, v.e2);
        chk("rs1_model", rs1_rdata, mread(v.ra1, 1'b1));
        chk("rs1_nofwd", rs1_rdata0, mread(v.ra1, 1'b0));
        dbg_q.push_back(mread(v.da, 1'b0));
        @(posedge clk);
        if (m_wen) m_regs[m_addr] = m_data;
        m_wen  = v.wen && (v.addr != 5'd0);
        m_addr = v.addr;
        m_data = v.data;
        #1;
        if (dbg_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dbg_sb: scoreboard empty");
        end else begin
            chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
        chk("dbg_nofwd", dbg_rdata0, dbg_rdata);
        chk("wb_busy", {31'd0, wb_busy}, {31'd0, m_wen});
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        rd_wen = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_raddr = '0; rs2_raddr = '0; dbg_raddr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_dbg", dbg_rdata, 32'd0);
        chk("rst_busy", {31'd0, wb_busy}, 32'd0);
        rst_n = 1'b1;

        // 1. All registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            v = '{1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i), 5'(i), 32'd0, 32'd0};
            step(v);
        end

        // 2. x5 write: ex bypass, wb bypass, array
        vecs.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 5'd5, 32'hDEADBEEF, 32'd0});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'd0});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF});
        // 3. back-to-back x7
        vecs.push_back('{1'b1, 5'd7, 32'd1, 5'd7, 5'd7, 5'd7, 32'd1, 32'd1});
        vecs.push_back('{1'b1, 5'd7, 32'd2, 5'd7, 5'd7, 5'd7, 32'd2, 32'd2});
        vecs.push_back('{1'b1, 5'd7, 32'd3, 5'd7, 5'd7, 5'd7, 32'd3, 32'd3});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 32'd3, 32'd3});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 32'd3, 32'd3});
        // 4. x0 write is discarded
        vecs.push_back('{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0});
        // 6. disabled write to x3 leaves old value
        vecs.push_back('{1'b1, 5'd3, 32'h33, 5'd3, 5'd7, 5'd3, 32'h33, 32'd3});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3, 32'h33, 32'd0});
        vecs.push_back('{1'b0, 5'd3, 32'hFFFF, 5'd3, 5'd3, 5'd3, 32'h33, 32'h33});
        vecs.push_back('{1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 5'd3, 32'h33, 32'd3});
        foreach (vecs[i]) step(vecs[i]);

        // 5. Reset during the commit cycle of x9
        @(negedge clk);
        rd_wen = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5A5A5;
        dbg_raddr = 5'd9;
        @(negedge clk);
        rd_wen = 1'b0; rd_addr = 5'd0; rd_data = 32'd0;
        chk("busy_pend", {31'd0, wb_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, wb_busy}, 32'd0);
        chk("rst_async_dbg", dbg_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 5'd0, 32'd0, 5'd9, 5'd5, 5'd9, 32'd0, 32'd0};
        step(v);
        v = '{1'b0, 5'd0, 32'd0, 5'd9, 5'd7, 5'd9, 32'd0, 32'd0};
        step(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
